// File: rtl/turbo_pkg.sv
// Shared types and helpers for the turbo encoder block controller.
package turbo_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ENC   = 2'd1,
    ST_TAIL  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam int K_DEF        = 40;
  localparam int F1_DEF       = 3;
  localparam int F2_DEF       = 10;
  localparam int TAIL_LEN_DEF = 3;
  localparam int MW           = 16;

  // Operands must already be below m, so one conditional subtract is enough.
  function automatic logic [MW-1:0] mod_add(input logic [MW-1:0] a,
                                            input logic [MW-1:0] b,
                                            input logic [MW-1:0] m);
    logic [MW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, m}) sum = sum - {1'b0, m};
    return sum[MW-1:0];
  endfunction

endpackage

// File: rtl/turbo_qpp_addr.sv
// Incremental QPP interleaver address generator: f(n+1)=f(n)+g(n), g(n+1)=g(n)+2*F2, all mod K.
module turbo_qpp_addr
  import turbo_pkg::*;
#(
  parameter int K  = K_DEF,
  parameter int F1 = F1_DEF,
  parameter int F2 = F2_DEF,
  parameter int AW = $clog2(K_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          step,
  output logic [AW-1:0] addr
);

  localparam logic [AW-1:0] G0 = AW'((F1 + F2) % K);
  localparam logic [AW-1:0] DG = AW'((2 * F2) % K);

  logic [AW-1:0] r_f;
  logic [AW-1:0] r_g;
  logic [AW-1:0] w_f_nxt;
  logic [AW-1:0] w_g_nxt;

  assign w_f_nxt = AW'(mod_add(MW'(r_f), MW'(r_g), MW'(K)));
  assign w_g_nxt = AW'(mod_add(MW'(r_g), MW'(DG), MW'(K)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f <= '0;
      r_g <= G0;
    end else if (clr) begin
      r_f <= '0;
      r_g <= G0;
    end else if (step) begin
      r_f <= w_f_nxt;
      r_g <= w_g_nxt;
    end
  end

  assign addr = r_f;

endmodule

// File: rtl/turbo_enc_ctrl.sv
// Turbo encoder block sequencer: buffers a K-bit block, then drives both RSC encoders
// through encode, termination and reset. Define TURBO_CTRL_PINGPONG_EN for two-bank zero-gap operation.
module turbo_enc_ctrl
  import turbo_pkg::*;
#(
  parameter int K        = K_DEF,
  parameter int F1       = F1_DEF,
  parameter int F2       = F2_DEF,
  parameter int TAIL_LEN = TAIL_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  output logic rsc_rst_n,
  output logic rsc_mode,
  output logic rsc_in1,
  output logic rsc_in2,
  output logic enc_active,
  output logic tail_active,
  output logic blk_done
);

  localparam int AW = $clog2(K);
  localparam int TW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

  state_t        r_state;
  logic [AW-1:0] r_wr_cnt;
  logic [AW-1:0] r_rd_cnt;
  logic [TW-1:0] r_tail_cnt;
  logic          r_in_ready;
  logic          r_rsc_rst_n;
  logic          r_rsc_mode;
  logic          r_rsc_in1;
  logic          r_rsc_in2;
  logic          r_enc_active;
  logic          r_tail_active;
  logic          r_blk_done;
  logic [K-1:0]  r_bank0;
`ifdef TURBO_CTRL_PINGPONG_EN
  logic [K-1:0]  r_bank1;
  logic          r_wbank;
  logic          r_wfull;
`endif

  logic          w_acc;
  logic          w_wlast;
  logic          w_swap;
  logic          w_rd1;
  logic          w_rd2;
  logic          w_enc_last;
  logic          w_tail_last;
  logic [AW-1:0] w_qaddr;

  assign w_acc       = in_valid && r_in_ready;
  assign w_wlast     = w_acc && (r_wr_cnt == AW'(K - 1));
  assign w_enc_last  = (r_rd_cnt == AW'(K - 1));
  assign w_tail_last = (r_tail_cnt == TW'(TAIL_LEN - 1));

`ifdef TURBO_CTRL_PINGPONG_EN
  // A block may also complete on the very FLUSH edge; treat that as full.
  assign w_swap = ((r_state == ST_LOAD) && w_wlast) ||
                  ((r_state == ST_FLUSH) && (r_wfull || w_wlast));
  assign w_rd1  = r_wbank ? r_bank0[r_rd_cnt] : r_bank1[r_rd_cnt];
  assign w_rd2  = r_wbank ? r_bank0[w_qaddr]  : r_bank1[w_qaddr];

  always_ff @(posedge clk) begin
    if (w_acc) begin
      if (r_wbank) r_bank1[r_wr_cnt] <= in_bit;
      else         r_bank0[r_wr_cnt] <= in_bit;
    end
  end
`else
  assign w_swap = (r_state == ST_LOAD) && w_wlast;
  assign w_rd1  = r_bank0[r_rd_cnt];
  assign w_rd2  = r_bank0[w_qaddr];

  always_ff @(posedge clk) begin
    if (w_acc) r_bank0[r_wr_cnt] <= in_bit;
  end
`endif

  turbo_qpp_addr #(
    .K  (K),
    .F1 (F1),
    .F2 (F2),
    .AW (AW)
  ) u_qpp (
    .clk  (clk),
    .rst  (rst),
    .clr  (r_state == ST_FLUSH),
    .step (r_state == ST_ENC),
    .addr (w_qaddr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_LOAD;
      r_wr_cnt      <= '0;
      r_rd_cnt      <= '0;
      r_tail_cnt    <= '0;
      r_in_ready    <= 1'b0;
      r_rsc_rst_n   <= 1'b0;
      r_rsc_mode    <= 1'b0;
      r_rsc_in1     <= 1'b0;
      r_rsc_in2     <= 1'b0;
      r_enc_active  <= 1'b0;
      r_tail_active <= 1'b0;
      r_blk_done    <= 1'b0;
`ifdef TURBO_CTRL_PINGPONG_EN
      r_wbank       <= 1'b0;
      r_wfull       <= 1'b0;
`endif
    end else begin
      r_rsc_rst_n   <= 1'b0;
      r_rsc_mode    <= 1'b0;
      r_rsc_in1     <= 1'b0;
      r_rsc_in2     <= 1'b0;
      r_enc_active  <= 1'b0;
      r_tail_active <= 1'b0;
      r_blk_done    <= 1'b0;

`ifdef TURBO_CTRL_PINGPONG_EN
      if (w_swap) begin
        r_wbank    <= ~r_wbank;
        r_wfull    <= 1'b0;
        r_wr_cnt   <= '0;
        r_in_ready <= 1'b1;
      end else if (w_wlast) begin
        r_wfull    <= 1'b1;
        r_wr_cnt   <= '0;
        r_in_ready <= 1'b0;
      end else begin
        if (w_acc) r_wr_cnt <= r_wr_cnt + AW'(1);
        r_in_ready <= !r_wfull;
      end
`else
      if (w_acc) r_wr_cnt <= w_wlast ? '0 : r_wr_cnt + AW'(1);
      r_in_ready <= ((r_state == ST_LOAD) && !w_wlast) || (r_state == ST_FLUSH);
`endif

      case (r_state)
        ST_LOAD: begin
          if (w_swap) r_state <= ST_ENC;
        end
        ST_ENC: begin
          r_rsc_in1    <= w_rd1;
          r_rsc_in2    <= w_rd2;
          r_rsc_rst_n  <= 1'b1;
          r_enc_active <= 1'b1;
          if (w_enc_last) begin
            r_rd_cnt <= '0;
            r_state  <= ST_TAIL;
          end else begin
            r_rd_cnt <= r_rd_cnt + AW'(1);
          end
        end
        ST_TAIL: begin
          r_rsc_mode    <= 1'b1;
          r_rsc_rst_n   <= 1'b1;
          r_tail_active <= 1'b1;
          if (w_tail_last) begin
            r_tail_cnt <= '0;
            r_state    <= ST_FLUSH;
          end else begin
            r_tail_cnt <= r_tail_cnt + TW'(1);
          end
        end
        ST_FLUSH: begin
          r_blk_done <= 1'b1;
          r_rd_cnt   <= '0;
          r_tail_cnt <= '0;
          r_state    <= w_swap ? ST_ENC : ST_LOAD;
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign rsc_rst_n   = r_rsc_rst_n;
  assign rsc_mode    = r_rsc_mode;
  assign rsc_in1     = r_rsc_in1;
  assign rsc_in2     = r_rsc_in2;
  assign enc_active  = r_enc_active;
  assign tail_active = r_tail_active;
  assign blk_done    = r_blk_done;

endmodule

// File: tb/tb_turbo_enc_ctrl.sv
// Scoreboard bench for turbo_enc_ctrl (default K=40, F1=3, F2=10, TAIL_LEN=3).
module tb_turbo_enc_ctrl;

  localparam int K        = 40;
  localparam int F1       = 3;
  localparam int F2       = 10;
  localparam int TAIL_LEN = 3;

  logic clk;
  logic rst;
  logic in_bit;
  logic in_valid;
  logic in_ready;
  logic rsc_rst_n;
  logic rsc_mode;
  logic rsc_in1;
  logic rsc_in2;
  logic enc_active;
  logic tail_active;
  logic blk_done;

  typedef struct packed {
    logic in1;
    logic in2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_bad = 0;

  turbo_enc_ctrl #(
    .K        (K),
    .F1       (F1),
    .F2       (F2),
    .TAIL_LEN (TAIL_LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_bit      (in_bit),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rsc_rst_n   (rsc_rst_n),
    .rsc_mode    (rsc_mode),
    .rsc_in1     (rsc_in1),
    .rsc_in2     (rsc_in2),
    .enc_active  (enc_active),
    .tail_active (tail_active),
    .blk_done    (blk_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int qpp(input int n);
    return (F1 * n + F2 * n * n) % K;
  endfunction

  // Output side of the scoreboard: every enc_active cycle consumes one expected pair.
  always @(negedge clk) begin
    if (enc_active) begin
      if (exp_q.size() == 0) begin
        chk_eq("sb_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk_eq("rsc_in1", 32'(rsc_in1), 32'(mon_e.in1));
        chk_eq("rsc_in2", 32'(rsc_in2), 32'(mon_e.in2));
      end
    end
  end

  task automatic send_block(input logic [K-1:0] bits, input bit rnd, input int start,
                            input bit hold, input logic hold_bit);
    int   idx;
    int   budget;
    bit   acc;
    exp_t e;
    idx    = start;
    budget = 0;
    while (idx < K && budget < 2000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_bit   = in_valid ? bits[idx] : 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      budget++;
    end
    chk_eq("send_cnt", 32'(idx), 32'(K));
    in_valid = hold;
    in_bit   = hold ? hold_bit : 1'b0;
    for (int n = 0; n < K; n++) begin
      e.in1 = bits[n];
      e.in2 = bits[qpp(n)];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(output int enc_c, output int mode_c, output int acc_c,
                           output bit acc_done);
    bit seen;
    int tail_bad;
    enc_c    = 0;
    mode_c   = 0;
    acc_c    = 0;
    acc_done = 1'b0;
    seen     = 1'b0;
    tail_bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (blk_done) begin
        seen = 1'b1;
        chk_eq("flush_rst_n", 32'(rsc_rst_n), 32'd0);
        chk_eq("flush_mode", 32'(rsc_mode), 32'd0);
        acc_done = in_valid && in_ready;
        @(posedge clk);
        #1;
        chk_eq("done_pulse", 32'(blk_done), 32'd0);
        break;
      end
      if (enc_active) enc_c++;
      if (rsc_mode) mode_c++;
      if (rsc_mode && (rsc_in1 || rsc_in2 || !tail_active || !rsc_rst_n)) tail_bad++;
      if (in_valid && in_ready) acc_c++;
    end
    chk_eq("done_seen", 32'(seen), 32'd1);
    chk_eq("tail_outputs", 32'(tail_bad), 32'd0);
  endtask

  task automatic run_block(input logic [K-1:0] bits, input bit rnd);
    int enc_c;
    int mode_c;
    int acc_c;
    bit acc_done;
    send_block(bits, rnd, 0, 1'b0, 1'b0);
    wait_done(enc_c, mode_c, acc_c, acc_done);
    chk_eq("enc_cycles", 32'(enc_c), 32'(K));
    chk_eq("tail_cycles", 32'(mode_c), 32'(TAIL_LEN));
`ifndef TURBO_CTRL_PINGPONG_EN
    chk_eq("busy_accepts", 32'(acc_c), 32'd0);
`endif
  endtask

  task automatic chk_reset_outputs(input string ph);
    chk_eq({ph, "_in_ready"}, 32'(in_ready), 32'd0);
    chk_eq({ph, "_rsc_rst_n"}, 32'(rsc_rst_n), 32'd0);
    chk_eq({ph, "_rsc_mode"}, 32'(rsc_mode), 32'd0);
    chk_eq({ph, "_rsc_in1"}, 32'(rsc_in1), 32'd0);
    chk_eq({ph, "_rsc_in2"}, 32'(rsc_in2), 32'd0);
    chk_eq({ph, "_enc_active"}, 32'(enc_active), 32'd0);
    chk_eq({ph, "_tail_active"}, 32'(tail_active), 32'd0);
    chk_eq({ph, "_blk_done"}, 32'(blk_done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [K-1:0] blk;
    logic [K-1:0] blk2;
    int           enc_c;
    int           mode_c;
    int           acc_c;
    bit           acc_done;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_eq("ready_after_rst", 32'(in_ready), 32'd1);

    // Single-hot blocks exercise individual interleaver addresses.
    blk = '0; blk[0] = 1'b1;
    run_block(blk, 1'b0);
    blk = '0; blk[13] = 1'b1;
    run_block(blk, 1'b0);
    blk = '0; blk[6] = 1'b1;
    run_block(blk, 1'b0);
    blk = '0; blk[19] = 1'b1;
    run_block(blk, 1'b0);

    // Random data with a randomly toggling in_valid.
    blk = K'({$urandom(), $urandom()});
    run_block(blk, 1'b1);
    blk = K'({$urandom(), $urandom()});
    run_block(blk, 1'b1);

    // Abort mid-ENC with reset, then a fresh block must start cleanly.
    blk = K'({$urandom(), $urandom()});
    send_block(blk, 1'b0, 0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    chk_eq("pre_abort_enc", 32'(enc_active), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    blk = ~blk;
    run_block(blk, 1'b1);

`ifndef TURBO_CTRL_PINGPONG_EN
    // in_valid held high across the block boundary.
    blk  = K'({$urandom(), $urandom()});
    blk2 = K'({$urandom(), $urandom()});
    send_block(blk, 1'b0, 0, 1'b1, blk2[0]);
    wait_done(enc_c, mode_c, acc_c, acc_done);
    chk_eq("gap_enc_cycles", 32'(enc_c), 32'(K));
    chk_eq("gap_tail_cycles", 32'(mode_c), 32'(TAIL_LEN));
    chk_eq("gap_accepts", 32'(acc_c), 32'd0);
    chk_eq("bit41_at_done", 32'(acc_done), 32'd1);
    send_block(blk2, 1'b0, 1, 1'b0, 1'b0);
    wait_done(enc_c, mode_c, acc_c, acc_done);
    chk_eq("gap2_enc_cycles", 32'(enc_c), 32'(K));
    chk_eq("gap2_tail_cycles", 32'(mode_c), 32'(TAIL_LEN));
`else
    // Two blocks streamed back to back into alternate banks.
    blk  = K'({$urandom(), $urandom()});
    blk2 = K'({$urandom(), $urandom()});
    send_block(blk, 1'b0, 0, 1'b0, 1'b0);
    send_block(blk2, 1'b0, 0, 1'b0, 1'b0);
    wait_done(enc_c, mode_c, acc_c, acc_done);
    chk_eq("pp_zero_gap", 32'(enc_active), 32'd1);
    wait_done(enc_c, mode_c, acc_c, acc_done);
    chk_eq("pp_enc_cycles", 32'(enc_c), 32'(K));
    chk_eq("pp_tail_cycles", 32'(mode_c), 32'(TAIL_LEN));
`endif

    repeat (3) @(posedge clk);
    #1;
    chk_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
